// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- write-back end of the pipeline.
//
// Holds the W pipeline slot that is captured from the M stage. From that slot
// it drives the GPR write port and the W-stage forwarding bus. It also forms
// the lwl/lwr merged load data and counts retired instructions.
//
// Ports
//   clk, reset      rising-edge clock; asynchronous reset, active low
//   stall, flush    hold / bubble the W slot (flush has priority)
//   m_*             M-stage slot contents to capture
//   rf_we/rf_waddr/rf_wdata   GPR write port (combinational from the slot)
//   w_fwd_valid     forwarding bus valid, identical to rf_we
//   retire_cnt      instructions retired since reset (wraps)
// ---------------------------------------------------------------------------
module wb_stage #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                flush,
   input  logic                m_valid,
   input  logic                m_regwrite,
   input  logic [1:0]          m_memtoreg,
   input  logic [1:0]          m_lwmode,
   input  logic [4:0]          m_waddr,
   input  logic [31:0]         m_alu,
   input  logic [31:0]         m_memrd,
   input  logic [1:0]          m_addr_lo,
   input  logic [31:0]         m_rt_old,
   input  logic [31:0]         m_pc8,
   output logic                rf_we,
   output logic [4:0]          rf_waddr,
   output logic [31:0]         rf_wdata,
   output logic                w_fwd_valid,
   output logic [RETIRE_W-1:0] retire_cnt
);

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_ALU  = 2'b01;
   localparam logic [1:0] SEL_LOAD = 2'b10;
   localparam logic [1:0] SEL_PC8  = 2'b11;

   localparam logic [1:0] LW_LEFT  = 2'b01;
   localparam logic [1:0] LW_RIGHT = 2'b10;

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic [1:0]  memtoreg;
      logic [1:0]  lwmode;
      logic [4:0]  waddr;
      logic [31:0] alu;
      logic [31:0] memrd;
      logic [1:0]  addrLo;
      logic [31:0] rtOld;
      logic [31:0] pc8;
   } slotT;

   slotT mSlot, wSlot;
   logic [31:0] loadData;
   logic        writeEn;

   assign mSlot = '{valid: m_valid, regwrite: m_regwrite, memtoreg: m_memtoreg,
                    lwmode: m_lwmode, waddr: m_waddr, alu: m_alu, memrd: m_memrd,
                    addrLo: m_addr_lo, rtOld: m_rt_old, pc8: m_pc8};

   // The instruction in W leaves the slot on any edge where it is not held,
   // including a flush edge (its GPR write still lands on that edge).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wSlot      <= '0;
         retire_cnt <= '0;
      end else begin
         if (wSlot.valid && (flush || !stall))
            retire_cnt <= retire_cnt + RETIRE_W'(1);
         if (flush)
            wSlot <= '0;
         else if (!stall)
            wSlot <= mSlot;
      end
   end

   // lwl fills the high bytes from memory, lwr fills the low bytes; the
   // untouched bytes keep the old rt value.
   always_comb begin
      loadData = wSlot.memrd;
      if (wSlot.lwmode == LW_LEFT) begin
         unique case (wSlot.addrLo)
            2'd0: loadData = {wSlot.memrd[7:0],  wSlot.rtOld[23:0]};
            2'd1: loadData = {wSlot.memrd[15:0], wSlot.rtOld[15:0]};
            2'd2: loadData = {wSlot.memrd[23:0], wSlot.rtOld[7:0]};
            2'd3: loadData = wSlot.memrd;
         endcase
      end else if (wSlot.lwmode == LW_RIGHT) begin
         unique case (wSlot.addrLo)
            2'd0: loadData = wSlot.memrd;
            2'd1: loadData = {wSlot.rtOld[31:24], wSlot.memrd[31:8]};
            2'd2: loadData = {wSlot.rtOld[31:16], wSlot.memrd[31:16]};
            2'd3: loadData = {wSlot.rtOld[31:8],  wSlot.memrd[31:24]};
         endcase
      end
   end

   always_comb begin
      rf_wdata = '0;
      unique case (wSlot.memtoreg)
         SEL_NONE: rf_wdata = '0;
         SEL_ALU:  rf_wdata = wSlot.alu;
         SEL_LOAD: rf_wdata = loadData;
         SEL_PC8:  rf_wdata = wSlot.pc8;
      endcase
   end

   // $0 is hard-wired zero, so writes to it are dropped here.
   assign writeEn     = wSlot.valid && wSlot.regwrite &&
                        (wSlot.memtoreg != SEL_NONE) && (wSlot.waddr != 5'd0);
   assign rf_we       = writeEn;
   assign w_fwd_valid = writeEn;
   assign rf_waddr    = writeEn ? wSlot.waddr : 5'd0;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          reset, stall, flush;
   logic          m_valid, m_regwrite;
   logic [1:0]    m_memtoreg, m_lwmode, m_addr_lo;
   logic [4:0]    m_waddr;
   logic [31:0]   m_alu, m_memrd, m_rt_old, m_pc8;
   logic          rf_we, w_fwd_valid;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic [RW-1:0] retire_cnt;

   int errs = 0;
   int checks = 0;

   wb_stage #(.RETIRE_W(RW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
      .m_lwmode(m_lwmode), .m_waddr(m_waddr), .m_alu(m_alu), .m_memrd(m_memrd),
      .m_addr_lo(m_addr_lo), .m_rt_old(m_rt_old), .m_pc8(m_pc8),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .w_fwd_valid(w_fwd_valid), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic        mdV, mdRw;
   logic [1:0]  mdMtr, mdLm, mdB;
   logic [4:0]  mdWa;
   logic [31:0] mdAlu, mdMem, mdRt, mdPc;
   int          mdCnt;

   function automatic logic [31:0] expData(input logic [1:0] mtr, input logic [1:0] lm,
                                           input logic [1:0] b, input logic [31:0] alu,
                                           input logic [31:0] mem, input logic [31:0] rt,
                                           input logic [31:0] pc);
      int sh;
      case (mtr)
         2'b01: return alu;
         2'b11: return pc;
         2'b10: begin
            if (lm == 2'b01) begin
               sh = 8 * (3 - int'(b));
               return (mem << sh) | (rt & ((32'h1 << sh) - 32'h1));
            end else if (lm == 2'b10) begin
               sh = 8 * int'(b);
               return (mem >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            end
            return mem;
         end
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         {mdV, mdRw, mdMtr, mdLm, mdB, mdWa} <= '0;
         {mdAlu, mdMem, mdRt, mdPc} <= '0;
         mdCnt <= 0;
      end else begin
         if (mdV && (flush || !stall)) mdCnt <= (mdCnt + 1) % (1 << RW);
         if (flush) begin
            {mdV, mdRw, mdMtr, mdLm, mdB, mdWa} <= '0;
            {mdAlu, mdMem, mdRt, mdPc} <= '0;
         end else if (!stall) begin
            mdV <= m_valid; mdRw <= m_regwrite; mdMtr <= m_memtoreg; mdLm <= m_lwmode;
            mdB <= m_addr_lo; mdWa <= m_waddr; mdAlu <= m_alu; mdMem <= m_memrd;
            mdRt <= m_rt_old; mdPc <= m_pc8;
         end
      end
   end

   // compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      logic weX;
      weX = mdV && mdRw && (mdMtr != 2'b00) && (mdWa != 5'd0);
      chk("m.rf_we", 32'(rf_we), 32'(weX));
      chk("m.fwd", 32'(w_fwd_valid), 32'(weX));
      chk("m.rf_waddr", 32'(rf_waddr), weX ? 32'(mdWa) : 32'h0);
      chk("m.rf_wdata", rf_wdata, expData(mdMtr, mdLm, mdB, mdAlu, mdMem, mdRt, mdPc));
      chk("m.retire", 32'(retire_cnt), 32'(mdCnt));
   end

   // ---------------- stimulus ----------------
   task automatic setM(input logic v, input logic rw, input logic [1:0] mtr,
                       input logic [1:0] lm, input logic [4:0] wa, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [1:0] b,
                       input logic [31:0] rt, input logic [31:0] pc);
      m_valid = v; m_regwrite = rw; m_memtoreg = mtr; m_lwmode = lm; m_waddr = wa;
      m_alu = alu; m_memrd = mem; m_addr_lo = b; m_rt_old = rt; m_pc8 = pc;
   endtask

   task automatic bubble();
      setM(0, 0, 2'b00, 2'b00, 5'd0, 0, 0, 2'b00, 0, 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      // 1: reset with busy inputs
      reset = 0; stall = 0; flush = 0;
      setM(1, 1, 2'b01, 2'b00, 5'd3, 32'hDEAD, 32'hBEEF, 2'b01, 32'h1, 32'h2);
      #3;
      chk("rst.we", 32'(rf_we), 0);
      chk("rst.wdata", rf_wdata, 0);
      chk("rst.cnt", 32'(retire_cnt), 0);
      cyc(); cyc();
      chk("rst.we2", 32'(rf_we), 0);
      chk("rst.cnt2", 32'(retire_cnt), 0);
      reset = 1;
      setM(1, 1, 2'b01, 2'b00, 5'd8, 32'h1234, 0, 2'b00, 0, 0);
      cyc();
      chk("addu.we", 32'(rf_we), 1);
      chk("addu.waddr", 32'(rf_waddr), 8);
      chk("addu.wdata", rf_wdata, 32'h1234);
      chk("addu.cnt0", 32'(retire_cnt), 0);
      bubble();
      cyc();
      chk("addu.cnt1", 32'(retire_cnt), 1);
      chk("bubble.we", 32'(rf_we), 0);

      // 2: load merges
      setM(1, 1, 2'b10, 2'b01, 5'd9, 0, 32'hAABBCCDD, 2'd1, 32'h11223344, 0);
      cyc(); chk("lwl.b1", rf_wdata, 32'hCCDD3344);
      m_addr_lo = 2'd3;
      cyc(); chk("lwl.b3", rf_wdata, 32'hAABBCCDD);
      m_lwmode = 2'b10; m_addr_lo = 2'd2;
      cyc(); chk("lwr.b2", rf_wdata, 32'h1122AABB);
      m_addr_lo = 2'd3;
      cyc(); chk("lwr.b3", rf_wdata, 32'h112233AA);
      m_lwmode = 2'b11; m_addr_lo = 2'd1;
      cyc(); chk("lw.mode3", rf_wdata, 32'hAABBCCDD);
      m_memtoreg = 2'b01; m_lwmode = 2'b01; m_alu = 32'h5555;
      cyc(); chk("alu.lmignored", rf_wdata, 32'h5555);

      // 3: jal and $0 suppression
      setM(1, 1, 2'b11, 2'b00, 5'd31, 0, 0, 2'b00, 0, 32'h00003008);
      cyc();
      chk("jal.wdata", rf_wdata, 32'h00003008);
      chk("jal.waddr", 32'(rf_waddr), 31);
      setM(1, 1, 2'b01, 2'b00, 5'd0, 32'h77, 0, 2'b00, 0, 0);
      cyc();
      chk("r0.we", 32'(rf_we), 0);
      chk("r0.waddr", 32'(rf_waddr), 0);
      base = mdCnt;
      bubble();
      cyc();
      chk("r0.counts", 32'(retire_cnt), 32'((base + 1) % 16));

      // 4: stall holds a lw for 3 cycles
      setM(1, 1, 2'b10, 2'b00, 5'd5, 0, 32'hCAFEF00D, 2'b00, 0, 0);
      cyc();
      base = mdCnt;
      stall = 1;
      setM(1, 1, 2'b01, 2'b00, 5'd6, 32'h999, 0, 2'b00, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall.we", 32'(rf_we), 1);
         chk("stall.waddr", 32'(rf_waddr), 5);
         chk("stall.wdata", rf_wdata, 32'hCAFEF00D);
         chk("stall.cnt", 32'(retire_cnt), 32'(base));
      end
      stall = 0;
      bubble();
      cyc();
      chk("stall.release", 32'(retire_cnt), 32'((base + 1) % 16));
      setM(1, 1, 2'b01, 2'b00, 5'd7, 32'h42, 0, 2'b00, 0, 0);
      cyc();
      stall = 1; flush = 1;
      cyc();
      chk("sf.we", 32'(rf_we), 0);
      chk("sf.wdata", rf_wdata, 0);
      stall = 0; flush = 0;
      bubble();
      cyc();

      // 5: wrap with 4-bit counter, then mid-stream async reset
      #2 reset = 0;
      #1 chk("wrap.clr", 32'(retire_cnt), 0);
      @(posedge clk); #1 reset = 1;
      for (int k = 1; k <= 16; k++) begin
         setM(1, 1, 2'b01, 2'b00, 5'(k), 32'(k), 0, 2'b00, 0, 0);
         cyc();
         chk("wrap.cnt", 32'(retire_cnt), 32'(k - 1));
      end
      bubble();
      cyc();
      chk("wrap.zero", 32'(retire_cnt), 0);
      setM(1, 1, 2'b01, 2'b00, 5'd4, 32'hA5, 0, 2'b00, 0, 0);
      cyc(); cyc(); cyc();
      chk("mid.precnt", 32'(retire_cnt), 2);
      #2 reset = 0;
      #1;
      chk("mid.cnt", 32'(retire_cnt), 0);
      chk("mid.we", 32'(rf_we), 0);
      chk("mid.wdata", rf_wdata, 0);
      cyc();
      chk("mid.held", 32'(rf_we), 0);
      reset = 1;
      cyc(); cyc();
      bubble();
      cyc();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
